// File: rtl/ahb_interconnect_pkg.sv
// Shared AHB-Lite bus types, default address map and small helpers used by
// the single-master interconnect and its built-in default slave.
package ahb_interconnect_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } transfer_kind;

  typedef logic [2:0] transfer_size;
  typedef logic [2:0] transfer_burst;
  typedef logic [3:0] transfer_prot;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  localparam int DEFAULT_SLAVE_COUNT = 4;

  // Element 0 is the rightmost entry.
  localparam logic [3:0][31:0] DEFAULT_SLAVE_BASE = {
    32'h0000_2000, 32'h0000_1000, 32'h0000_0800, 32'h0000_0000
  };
  localparam logic [3:0][31:0] DEFAULT_SLAVE_MASK = {
    32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F800, 32'hFFFF_F800
  };

  function automatic logic is_active(input transfer_kind t);
    return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped transfers: two-cycle ERROR response plus
// saturating error counter and last-offending-address capture.
module ahb_default_slave
  import ahb_interconnect_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hready,
  input  logic                  unmapped,
  input  transfer_kind          trans,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output transfer_response      resp,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  ds_state_t             state_r;
  ds_state_t             state_next_s;
  logic                  err_start_s;
  logic [15:0]           err_count_r;
  logic [ADDR_WIDTH-1:0] err_addr_r;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= DS_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and response decode
  always_comb begin
    state_next_s = state_r;
    ready        = 1'b1;
    resp         = RESP_OKAY;
    err_start_s  = 1'b0;
    case (state_r)
      DS_IDLE: begin
        if (hready && unmapped && is_active(trans)) begin
          state_next_s = DS_ERR1;
          err_start_s  = 1'b1;
        end else begin
          state_next_s = DS_IDLE;
        end
      end
      DS_ERR1: begin
        ready        = 1'b0;
        resp         = RESP_ERROR;
        state_next_s = DS_ERR2;
      end
      DS_ERR2: begin
        // Last error cycle has HREADY high, so the next address is taken now.
        resp = RESP_ERROR;
        if (unmapped && is_active(trans)) begin
          state_next_s = DS_ERR1;
          err_start_s  = 1'b1;
        end else begin
          state_next_s = DS_IDLE;
        end
      end
      default: begin
        state_next_s = DS_IDLE;
      end
    endcase
  end

  // Error telemetry, updated on the edge that enters DS_ERR1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count_r <= 16'h0000;
      err_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else if (err_start_s) begin
      err_count_r <= sat_inc16(err_count_r);
      err_addr_r  <= addr;
    end
  end

  assign err_count = err_count_r;
  assign err_addr  = err_addr_r;

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decode to N slave selects,
// registered data-phase owner and response mux, with a built-in default slave.
module ahb_interconnect
  import ahb_interconnect_pkg::*;
#(
  parameter int SLAVE_COUNT = DEFAULT_SLAVE_COUNT,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [SLAVE_COUNT-1:0][ADDR_WIDTH-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
  parameter logic [SLAVE_COUNT-1:0][ADDR_WIDTH-1:0] SLAVE_MASK = DEFAULT_SLAVE_MASK
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [ADDR_WIDTH-1:0]                 m_addr,
  input  transfer_kind                          m_trans,
  input  logic                                  m_write,
  input  transfer_size                          m_size,
  input  transfer_burst                         m_burst,
  input  transfer_prot                          m_prot,
  input  logic                                  m_mastlock,
  input  logic [DATA_WIDTH-1:0]                 m_wdata,
  output logic [DATA_WIDTH-1:0]                 m_rdata,
  output logic                                  m_ready,
  output transfer_response                      m_resp,
  output logic [SLAVE_COUNT-1:0]                s_sel,
  output logic [ADDR_WIDTH-1:0]                 s_addr,
  output transfer_kind                          s_trans,
  output logic                                  s_write,
  output transfer_size                          s_size,
  output transfer_burst                         s_burst,
  output transfer_prot                          s_prot,
  output logic                                  s_mastlock,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic                                  s_ready_in,
  input  logic [SLAVE_COUNT-1:0][DATA_WIDTH-1:0] s_rdata,
  input  logic [SLAVE_COUNT-1:0]                s_ready,
  input  logic [SLAVE_COUNT-1:0]                s_resp,
  output logic [15:0]                           err_count,
  output logic [ADDR_WIDTH-1:0]                 err_addr
);

  localparam int IDX_W = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

  logic [SLAVE_COUNT-1:0] hit_s;
  logic [SLAVE_COUNT-1:0] sel_s;
  logic [IDX_W-1:0]       idx_s;
  logic                   any_hit_s;
  logic [IDX_W-1:0]       dsel_idx_r;
  logic                   dsel_dflt_r;
  logic                   dsel_active_r;
  logic                   dflt_ready_s;
  transfer_response       dflt_resp_s;

  // Address match against every slave window
  always_comb begin
    hit_s = {SLAVE_COUNT{1'b0}};
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      hit_s[i] = ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]);
    end
  end

  // Lowest-index priority select; scanning downwards leaves the lowest hit
  always_comb begin
    sel_s     = {SLAVE_COUNT{1'b0}};
    idx_s     = {IDX_W{1'b0}};
    any_hit_s = 1'b0;
    for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        idx_s     = i[IDX_W-1:0];
        any_hit_s = 1'b1;
      end else begin
        any_hit_s = any_hit_s;
      end
    end
    if (any_hit_s) begin
      sel_s[idx_s] = 1'b1;
    end else begin
      sel_s = {SLAVE_COUNT{1'b0}};
    end
  end

  // Data-phase owner, advances only when the bus is ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dsel_idx_r    <= {IDX_W{1'b0}};
      dsel_dflt_r   <= 1'b1;
      dsel_active_r <= 1'b0;
    end else if (m_ready) begin
      dsel_idx_r    <= idx_s;
      dsel_dflt_r   <= ~any_hit_s;
      dsel_active_r <= is_active(m_trans);
    end
  end

  ahb_default_slave #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dflt (
    .clock     (clock),
    .reset     (reset),
    .hready    (m_ready),
    .unmapped  (~any_hit_s),
    .trans     (m_trans),
    .addr      (m_addr),
    .ready     (dflt_ready_s),
    .resp      (dflt_resp_s),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  // Response mux; read data is only forwarded for an active data phase
  always_comb begin
    m_rdata = {DATA_WIDTH{1'b0}};
    m_ready = dflt_ready_s;
    m_resp  = dflt_resp_s;
    if (dsel_dflt_r) begin
      m_rdata = {DATA_WIDTH{1'b0}};
    end else begin
      m_ready = s_ready[dsel_idx_r];
      m_resp  = transfer_response'(s_resp[dsel_idx_r]);
      if (dsel_active_r) begin
        m_rdata = s_rdata[dsel_idx_r];
      end else begin
        m_rdata = {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign s_sel      = sel_s;
  assign s_addr     = m_addr;
  assign s_trans    = m_trans;
  assign s_write    = m_write;
  assign s_size     = m_size;
  assign s_burst    = m_burst;
  assign s_prot     = m_prot;
  assign s_mastlock = m_mastlock;
  assign s_wdata    = m_wdata;
  assign s_ready_in = m_ready;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect: table of single transfers plus
// hand-written wait-state, error, reset and saturation sequences.
module tb_ahb_interconnect;
  import ahb_interconnect_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [31:0]           m_addr;
  transfer_kind          m_trans;
  logic                  m_write;
  transfer_size          m_size;
  transfer_burst         m_burst;
  transfer_prot          m_prot;
  logic                  m_mastlock;
  logic [31:0]           m_wdata;
  logic [31:0]           m_rdata;
  logic                  m_ready;
  transfer_response      m_resp;
  logic [3:0]            s_sel;
  logic [31:0]           s_addr;
  transfer_kind          s_trans;
  logic                  s_write;
  transfer_size          s_size;
  transfer_burst         s_burst;
  transfer_prot          s_prot;
  logic                  s_mastlock;
  logic [31:0]           s_wdata;
  logic                  s_ready_in;
  logic [3:0][31:0]      s_rdata;
  logic [3:0]            s_ready;
  logic [3:0]            s_resp;
  logic [15:0]           err_count;
  logic [31:0]           err_addr;

  logic [31:0]           ov_m_rdata;
  logic                  ov_m_ready;
  transfer_response      ov_m_resp;
  logic [3:0]            ov_s_sel;
  logic [31:0]           ov_s_addr;
  transfer_kind          ov_s_trans;
  logic                  ov_s_write;
  transfer_size          ov_s_size;
  transfer_burst         ov_s_burst;
  transfer_prot          ov_s_prot;
  logic                  ov_s_mastlock;
  logic [31:0]           ov_s_wdata;
  logic                  ov_s_ready_in;
  logic [15:0]           ov_err_count;
  logic [31:0]           ov_err_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ahb_interconnect dut (
    .clock(clock), .reset(reset),
    .m_addr(m_addr), .m_trans(m_trans), .m_write(m_write), .m_size(m_size),
    .m_burst(m_burst), .m_prot(m_prot), .m_mastlock(m_mastlock), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_resp(m_resp),
    .s_sel(s_sel), .s_addr(s_addr), .s_trans(s_trans), .s_write(s_write),
    .s_size(s_size), .s_burst(s_burst), .s_prot(s_prot), .s_mastlock(s_mastlock),
    .s_wdata(s_wdata), .s_ready_in(s_ready_in),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_resp(s_resp),
    .err_count(err_count), .err_addr(err_addr)
  );

  // Overlapping map: slave2 (0x000-0xFFF) overlaps slaves 0 and 1
  ahb_interconnect #(
    .SLAVE_BASE({32'h0000_2000, 32'h0000_0000, 32'h0000_0800, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F800, 32'hFFFF_F800})
  ) dut_ov (
    .clock(clock), .reset(reset),
    .m_addr(m_addr), .m_trans(m_trans), .m_write(m_write), .m_size(m_size),
    .m_burst(m_burst), .m_prot(m_prot), .m_mastlock(m_mastlock), .m_wdata(m_wdata),
    .m_rdata(ov_m_rdata), .m_ready(ov_m_ready), .m_resp(ov_m_resp),
    .s_sel(ov_s_sel), .s_addr(ov_s_addr), .s_trans(ov_s_trans), .s_write(ov_s_write),
    .s_size(ov_s_size), .s_burst(ov_s_burst), .s_prot(ov_s_prot),
    .s_mastlock(ov_s_mastlock), .s_wdata(ov_s_wdata), .s_ready_in(ov_s_ready_in),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_resp(s_resp),
    .err_count(ov_err_count), .err_addr(ov_err_addr)
  );

  typedef struct {
    logic [31:0]      addr;
    transfer_kind     trans;
    logic [3:0]       sel;
    logic             ready;
    transfer_response resp;
    logic [31:0]      rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input transfer_kind t);
    m_addr  = a;
    m_trans = t;
  endtask

  task automatic err_pair(input logic [31:0] a, input logic [15:0] exp_cnt);
    tick();
    drive(a, TRANS_NONSEQ);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    #2;
    check("err1_ready", m_ready, 1'b0);
    check("err1_resp", m_resp, RESP_ERROR);
    check("err_count", err_count, exp_cnt);
    check("err_addr", err_addr, a);
    tick();
    #2;
    check("err2_ready", m_ready, 1'b1);
    check("err2_resp", m_resp, RESP_ERROR);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0004, TRANS_NONSEQ, 4'b0001, 1'b1, RESP_OKAY, 32'hA0A0_0000};
    vecs[1] = '{32'h0000_0804, TRANS_SEQ,    4'b0010, 1'b1, RESP_OKAY, 32'hA0A0_0001};
    vecs[2] = '{32'h0000_1FFC, TRANS_NONSEQ, 4'b0100, 1'b1, RESP_OKAY, 32'hA0A0_0002};
    vecs[3] = '{32'h0000_2000, TRANS_NONSEQ, 4'b1000, 1'b1, RESP_OKAY, 32'hA0A0_0003};
    vecs[4] = '{32'h0000_3FFC, TRANS_SEQ,    4'b1000, 1'b1, RESP_OKAY, 32'hA0A0_0003};
    vecs[5] = '{32'h0000_9000, TRANS_IDLE,   4'b0000, 1'b1, RESP_OKAY, 32'h0000_0000};
    vecs[6] = '{32'h0000_4000, TRANS_BUSY,   4'b0000, 1'b1, RESP_OKAY, 32'h0000_0000};
    vecs[7] = '{32'hFFFF_F800, TRANS_IDLE,   4'b0000, 1'b1, RESP_OKAY, 32'h0000_0000};

    reset      = 1'b1;
    drive(32'h0000_0000, TRANS_IDLE);
    m_write    = 1'b1;
    m_size     = 3'd2;
    m_burst    = 3'd1;
    m_prot     = 4'h3;
    m_mastlock = 1'b0;
    m_wdata    = 32'hCAFE_F00D;
    s_rdata[0] = 32'hA0A0_0000;
    s_rdata[1] = 32'hA0A0_0001;
    s_rdata[2] = 32'hA0A0_0002;
    s_rdata[3] = 32'hA0A0_0003;
    s_ready    = 4'b1111;
    s_resp     = 4'b0000;
    #12;
    check("rst_ready", m_ready, 1'b1);
    check("rst_resp", m_resp, RESP_OKAY);
    check("rst_rdata", m_rdata, 32'h0000_0000);
    check("rst_err_count", err_count, 16'h0000);
    check("rst_err_addr", err_addr, 32'h0000_0000);
    check("pass", {s_addr, s_trans, s_write, s_size, s_burst, s_prot, s_mastlock, s_wdata, s_ready_in},
          {32'h0000_0000, TRANS_IDLE, 1'b1, 3'd2, 3'd1, 4'h3, 1'b0, 32'hCAFE_F00D, 1'b1});
    check("ov_pass", {ov_s_addr, ov_s_trans, ov_s_write, ov_s_size, ov_s_burst, ov_s_prot,
                      ov_s_mastlock, ov_s_wdata, ov_s_ready_in, ov_m_ready, ov_m_resp,
                      ov_m_rdata, ov_err_count, ov_err_addr},
          {32'h0000_0000, TRANS_IDLE, 1'b1, 3'd2, 3'd1, 4'h3, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b1,
           RESP_OKAY, 32'h0000_0000, 16'h0000, 32'h0000_0000});
    reset = 1'b0;

    // Table: one transfer per entry, address phase then data phase
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(vecs[i].addr, vecs[i].trans);
      #2;
      check("tbl_sel", s_sel, vecs[i].sel);
      tick();
      drive(32'h0000_0000, TRANS_IDLE);
      #2;
      check("tbl_ready", m_ready, vecs[i].ready);
      check("tbl_resp", m_resp, vecs[i].resp);
      check("tbl_rdata", m_rdata, vecs[i].rdata);
    end
    check("tbl_err_count", err_count, 16'h0000);

    // Overlapping windows resolve to the lowest index
    drive(32'h0000_0100, TRANS_IDLE);
    #1;
    check("ov_sel_0100", ov_s_sel, 4'b0001);
    drive(32'h0000_09FC, TRANS_IDLE);
    #1;
    check("ov_sel_09fc", ov_s_sel, 4'b0010);
    drive(32'h0000_0000, TRANS_IDLE);

    // Slave 1 inserts two wait states; the pending next address must wait
    tick();
    drive(32'h0000_0804, TRANS_NONSEQ);
    s_ready[1] = 1'b0;
    #2;
    check("wait_sel", s_sel, 4'b0010);
    check("wait_addr_ready", m_ready, 1'b1);
    tick();
    drive(32'h0000_2000, TRANS_NONSEQ);
    #2;
    check("wait1_ready", m_ready, 1'b0);
    check("wait1_sel", s_sel, 4'b1000);
    tick();
    #2;
    check("wait2_ready", m_ready, 1'b0);
    tick();
    s_ready[1] = 1'b1;
    s_rdata[1] = 32'h1234_5678;
    #2;
    check("wait_done_ready", m_ready, 1'b1);
    check("wait_done_rdata", m_rdata, 32'h1234_5678);
    check("wait_done_resp", m_resp, RESP_OKAY);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    s_rdata[1] = 32'hA0A0_0001;
    #2;
    check("after_wait_rdata", m_rdata, 32'hA0A0_0003);

    // Unmapped NONSEQ: two-cycle ERROR, then back to OKAY
    tick();
    drive(32'h0000_9000, TRANS_NONSEQ);
    #2;
    check("unmap_sel", s_sel, 4'b0000);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    #2;
    check("unmap_e1_ready", m_ready, 1'b0);
    check("unmap_e1_resp", m_resp, RESP_ERROR);
    check("unmap_count", err_count, 16'h0001);
    check("unmap_addr", err_addr, 32'h0000_9000);
    tick();
    #2;
    check("unmap_e2_ready", m_ready, 1'b1);
    check("unmap_e2_resp", m_resp, RESP_ERROR);
    tick();
    #2;
    check("unmap_done_ready", m_ready, 1'b1);
    check("unmap_done_resp", m_resp, RESP_OKAY);

    // Unmapped IDLE: zero-wait OKAY, not counted
    tick();
    drive(32'h0000_9000, TRANS_IDLE);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    #2;
    check("unmap_idle_ready", m_ready, 1'b1);
    check("unmap_idle_resp", m_resp, RESP_OKAY);
    check("unmap_idle_count", err_count, 16'h0001);

    // Back-to-back unmapped transfers after a fresh reset
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    drive(32'h0000_9000, TRANS_NONSEQ);
    tick();
    drive(32'h0000_A000, TRANS_NONSEQ);
    #2;
    check("b2b_e1_ready", m_ready, 1'b0);
    check("b2b_e1_count", err_count, 16'h0001);
    tick();
    #2;
    check("b2b_e2_ready", m_ready, 1'b1);
    check("b2b_e2_resp", m_resp, RESP_ERROR);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    #2;
    check("b2b_2nd_e1_ready", m_ready, 1'b0);
    check("b2b_2nd_e1_resp", m_resp, RESP_ERROR);
    check("b2b_count", err_count, 16'h0002);
    check("b2b_addr", err_addr, 32'h0000_A000);
    tick();
    #2;
    check("b2b_2nd_e2_ready", m_ready, 1'b1);
    check("b2b_2nd_e2_resp", m_resp, RESP_ERROR);
    tick();
    #2;
    check("b2b_done_resp", m_resp, RESP_OKAY);

    // Asynchronous reset in DS_ERR1
    tick();
    drive(32'h0000_9000, TRANS_NONSEQ);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    #2;
    check("rst_err1_pre", m_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_err1_ready", m_ready, 1'b1);
    check("rst_err1_resp", m_resp, RESP_OKAY);
    check("rst_err1_count", err_count, 16'h0000);
    check("rst_err1_addr", err_addr, 32'h0000_0000);
    reset = 1'b0;
    tick();
    #2;
    check("rst_err1_after", m_ready, 1'b1);

    // Asynchronous reset while slave 3 is holding the bus
    tick();
    s_rdata[3] = 32'hDEAD_BEEF;
    s_ready[3] = 1'b0;
    drive(32'h0000_2000, TRANS_NONSEQ);
    tick();
    drive(32'h0000_0000, TRANS_IDLE);
    #2;
    check("rst_wait_pre_ready", m_ready, 1'b0);
    check("rst_wait_pre_rdata", m_rdata, 32'hDEAD_BEEF);
    reset = 1'b1;
    #1;
    check("rst_wait_ready", m_ready, 1'b1);
    check("rst_wait_rdata", m_rdata, 32'h0000_0000);
    check("rst_wait_resp", m_resp, RESP_OKAY);
    reset = 1'b0;
    s_ready[3] = 1'b1;
    s_rdata[3] = 32'hA0A0_0003;

    // Saturation from a preloaded count near the top
    tick();
    force dut.u_dflt.err_count_r = 16'hFFFE;
    #1;
    release dut.u_dflt.err_count_r;
    err_pair(32'h0000_9004, 16'hFFFF);
    err_pair(32'h0000_9008, 16'hFFFF);
    err_pair(32'h0000_900C, 16'hFFFF);
    tick();
    #2;
    check("sat_done_resp", m_resp, RESP_OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
